// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 front-end: header parse, sequence tracking and
// dispatcher drive with message-count accounting.
module mold_seq_ctrl #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int SID_W      = 80,
  parameter int SEQ_W      = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  udp_valid_i,
  input  logic [AXI_DATA_W-1:0] udp_data_i,
  input  logic [AXI_KEEP_W-1:0] udp_keep_i,
  input  logic                  udp_last_i,
  output logic                  disp_valid_o,
  output logic [AXI_DATA_W-1:0] disp_data_o,
  output logic [AXI_KEEP_W-1:0] disp_keep_o,
  output logic                  disp_init_v_o,
  output logic                  disp_last_o,
  input  logic                  disp_msg_end_v_i,
  output logic                  sync_o,
  output logic [SID_W-1:0]      session_o,
  output logic [SEQ_W-1:0]      seq_exp_o,
  output logic                  gap_v_o,
  output logic [SEQ_W-1:0]      gap_start_o,
  output logic [SEQ_W-1:0]      gap_cnt_o,
  output logic                  dup_v_o,
  output logic                  sess_err_o,
  output logic                  runt_o,
  output logic                  cnt_err_o,
  output logic                  eos_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_HDR2,
    S_PASS,
    S_DROP
  } state_e;

  state_e               state_q;
  logic [SID_W-17:0]    sid_hi_q;
  logic [15:0]          sid_lo_q;
  logic [SEQ_W-17:0]    seq_hi_q;
  logic [SID_W-1:0]     sess_q;
  logic                 sync_q;
  logic [SEQ_W-1:0]     exp_q;
  logic                 eos_q;
  logic [SEQ_W-1:0]     gap_start_q;
  logic [SEQ_W-1:0]     gap_cnt_q;
  logic                 gap_v_q;
  logic                 dup_v_q;
  logic                 sess_err_q;
  logic                 runt_q;
  logic                 cnt_err_q;
  logic [CNT_W-1:0]     rem_q;
  logic [CNT_W-1:0]     rem_d;
  logic                 ovf_q;
  logic                 ovf_d;

  logic [63:0]          bs;
  logic [SEQ_W-1:0]     seq_c;
  logic [CNT_W-1:0]     cnt_c;
  logic [SID_W-1:0]     sid_c;
  logic                 hdr2_v;
  logic                 eos_cnt;
  logic                 live;
  logic                 match;
  logic                 acc;
  logic                 fwd0;
  logic                 gap_hit;
  logic                 dup_hit;
  logic                 sess_hit;
  logic                 runt_hit;
  logic                 cnt_hit;
  logic [CNT_W-1:0]     rem_now;
  logic                 ovf_now;

  // Byte 0 on the wire is the most significant header byte.
  function automatic logic [63:0] bswap(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  always_comb begin
    bs      = bswap(udp_data_i);
    seq_c   = {seq_hi_q, bs[63:48]};
    cnt_c   = bs[47:32];
    sid_c   = {sid_hi_q, sid_lo_q};
    hdr2_v  = udp_valid_i & (state_q == S_HDR2);
    eos_cnt = (cnt_c == '1);
    live    = hdr2_v & ~eos_q & ~eos_cnt;
    match   = (sid_c == sess_q);
    acc     = live & (~sync_q | (match & (seq_c >= exp_q)));
    gap_hit = live & sync_q & match & (seq_c > exp_q);
    dup_hit = live & sync_q & match & (seq_c < exp_q);
    sess_hit = live & sync_q & ~match;
    fwd0    = acc & (cnt_c != '0);
    runt_hit = udp_valid_i & udp_last_i &
               ((state_q == S_IDLE) | (state_q == S_HDR1));
  end

  assign disp_valid_o  = fwd0 | (udp_valid_i & (state_q == S_PASS));
  assign disp_init_v_o = fwd0;
  assign disp_last_o   = udp_last_i & disp_valid_o;
  assign disp_data_o   = udp_data_i;
  assign disp_keep_o   = udp_keep_i;

  // An end pulse on the loading beat counts against the new count.
  always_comb begin
    rem_now = acc ? cnt_c : rem_q;
    ovf_now = acc ? 1'b0 : ovf_q;
    rem_d   = rem_now;
    ovf_d   = ovf_now;
    if (disp_msg_end_v_i) begin
      if (rem_now == '0) ovf_d = 1'b1;
      else               rem_d = rem_now - 1'b1;
    end
    cnt_hit = disp_last_o & ((rem_d != '0) | ovf_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sid_hi_q    <= '0;
      sid_lo_q    <= '0;
      seq_hi_q    <= '0;
      sess_q      <= '0;
      sync_q      <= 1'b0;
      exp_q       <= '0;
      eos_q       <= 1'b0;
      gap_start_q <= '0;
      gap_cnt_q   <= '0;
      gap_v_q     <= 1'b0;
      dup_v_q     <= 1'b0;
      sess_err_q  <= 1'b0;
      runt_q      <= 1'b0;
      cnt_err_q   <= 1'b0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      gap_v_q    <= gap_hit;
      dup_v_q    <= dup_hit;
      sess_err_q <= sess_hit;
      runt_q     <= runt_hit;
      cnt_err_q  <= cnt_hit;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      if (gap_hit) begin
        gap_start_q <= exp_q;
        gap_cnt_q   <= seq_c - exp_q;
      end
      if (acc) exp_q <= seq_c + SEQ_W'(cnt_c);
      if (acc & ~sync_q) begin
        sync_q <= 1'b1;
        sess_q <= sid_c;
      end
      if (hdr2_v & eos_cnt) eos_q <= 1'b1;
      if (udp_valid_i) begin
        unique case (state_q)
          S_IDLE: begin
            sid_hi_q <= bs;
            state_q  <= udp_last_i ? S_IDLE : S_HDR1;
          end
          S_HDR1: begin
            sid_lo_q <= bs[63:48];
            seq_hi_q <= bs[47:0];
            state_q  <= udp_last_i ? S_IDLE : S_HDR2;
          end
          S_HDR2: begin
            if (udp_last_i) state_q <= S_IDLE;
            else if (fwd0)  state_q <= S_PASS;
            else            state_q <= S_DROP;
          end
          S_PASS, S_DROP: begin
            if (udp_last_i) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sync_o      = sync_q;
  assign session_o   = sess_q;
  assign seq_exp_o   = exp_q;
  assign gap_v_o     = gap_v_q;
  assign gap_start_o = gap_start_q;
  assign gap_cnt_o   = gap_cnt_q;
  assign dup_v_o     = dup_v_q;
  assign sess_err_o  = sess_err_q;
  assign runt_o      = runt_q;
  assign cnt_err_o   = cnt_err_q;
  assign eos_o       = eos_q;

endmodule

// File: doc/mold_seq_ctrl.md
Name: mold_seq_ctrl

Overview:
- Front-end controller for the MoldUDP64 message dispatcher.
- Parses the 20-byte MoldUDP64 header (session 10 B, sequence number 8 B, message count 2 B) from the incoming 64-bit UDP payload beat stream.
- Decides per packet whether to accept, drop as duplicate, or accept with a gap report. Drives the dispatcher's valid/init/last and tracks the expected sequence number.
- Checks the dispatcher's message-end pulses against the header message count.

Parameters:
AXI_DATA_W, 64, payload beat width (only 64 supported)
AXI_KEEP_W, AXI_DATA_W/8, byte-enable width
SID_W, 80, session id width
SEQ_W, 64, sequence number width
CNT_W, 16, message count width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
udp_valid_i  in  1  payload beat valid
udp_data_i  in  AXI_DATA_W  payload beat, byte 0 = bits [7:0] = first wire byte
udp_keep_i  in  AXI_KEEP_W  byte enables
udp_last_i  in  1  last beat of UDP payload
disp_valid_o  out  1  beat valid to dispatcher
disp_data_o  out  AXI_DATA_W  = udp_data_i
disp_keep_o  out  AXI_KEEP_W  = udp_keep_i
disp_init_v_o  out  1  third header beat (first message length at bytes 4-5)
disp_last_o  out  1  = udp_last_i & disp_valid_o
disp_msg_end_v_i  in  1  message-end pulse from dispatcher
sync_o  out  1  session locked
session_o  out  SID_W  locked session id
seq_exp_o  out  SEQ_W  next expected sequence number
gap_v_o  out  1  gap pulse
gap_start_o  out  SEQ_W  first missing sequence number
gap_cnt_o  out  SEQ_W  number of missing messages
dup_v_o  out  1  duplicate-drop pulse
sess_err_o  out  1  session-mismatch pulse
runt_o  out  1  short-packet pulse
cnt_err_o  out  1  message-count mismatch pulse
eos_o  out  1  end-of-session seen, sticky

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; `sync_o` = 0; `eos_o` = 0.
- Reset always lands on a packet boundary (upstream shares the reset).
- Header field order is big-endian:
  - Session: beat0 bytes 0-7, beat1 bytes 0-1.
  - Seq: beat1 bytes 2-7, beat2 bytes 0-1.
  - Count: beat2 bytes 2-3.
- FSM states, advancing only on `udp_valid_i`:
  - IDLE: capture session[79:16] -> HDR1.
  - HDR1: capture session[15:0] and seq[63:16] -> HDR2.
  - HDR2: seq and count complete. The decision is combinational on this beat. Go to PASS if accepted and not last, else DROP, or IDLE if last.
  - PASS: forward beats; on last -> IDLE.
  - DROP: swallow beats; on last -> IDLE.
- Runt: `udp_last_i` in IDLE or HDR1 -> `runt_o` pulse, return to IDLE, no dispatcher output.
- Decision on the HDR2 beat, with seq = S, count = C, expected = E:
  - C == 0xFFFF: set `eos_o`, drop, no gap check.
  - `sync_o` == 0: lock `session_o`, set `sync_o`, accept, no gap.
  - Session differs from `session_o`: `sess_err_o` pulse, drop.
  - S < E: `dup_v_o` pulse, drop the whole packet. Partial overlap is also dropped.
  - S > E: `gap_v_o` pulse with `gap_start_o` = E and `gap_cnt_o` = S-E, then accept.
  - S == E: accept.
  - On accept: E <= S+C, wrapping modulo 2^SEQ_W, unsigned compare, no wrap awareness.
  - C == 0 (heartbeat): gap check and E update still apply; the dispatcher sees nothing (packet treated as DROP).
- Dispatcher drive, combinational with zero latency:
  - `disp_valid_o` = `udp_valid_i` & ((HDR2 & accept & C != 0) | PASS).
  - `disp_init_v_o` = `udp_valid_i` & HDR2 & accept & C != 0.
  - Beats 0-1 never reach the dispatcher.
- Message accounting:
  - `msg_rem` (CNT_W) loads C on an accepted HDR2 beat.
  - `msg_rem` decrements on each `disp_msg_end_v_i`, saturating at 0.
  - On the accepted packet's last beat, a simultaneous end pulse is counted first. If `msg_rem` != 0, or an end pulse arrives while `msg_rem` == 0, pulse `cnt_err_o`.
- Pulse timing: all pulses (`gap_v_o`, `dup_v_o`, `sess_err_o`, `runt_o`, `cnt_err_o`) are registered, high exactly one cycle, in the cycle after the triggering beat. `gap_start_o` and `gap_cnt_o` hold until the next gap.
- `seq_exp_o` and `session_o` update in the cycle after the HDR2 beat.
- `eos_o` clears only on reset. After `eos_o`, all further packets are dropped, with no pulses other than `runt_o`.

Test Plan:
- Reset, then packet S=100, C=2, two messages -> `sync_o`=1, `seq_exp_o`=102, init on beat 2, no error pulses.
- Next packet S=102, C=1 -> accepted, `seq_exp_o`=103, `gap_v_o` stays 0.
- Next packet S=110, C=3 -> `gap_v_o` one cycle with `gap_start_o`=103 and `gap_cnt_o`=7; accepted; `seq_exp_o`=113.
- Packet S=105, then packet with a different session id -> `dup_v_o` pulse, then `sess_err_o` pulse; `disp_valid_o` never high; `seq_exp_o` stays 113.
- Two-beat packet (last on beat1) -> `runt_o` pulse, FSM back to IDLE, next full packet accepted normally.
- Packet C=2 with only one `disp_msg_end_v_i` -> `cnt_err_o` pulse after last. Then C=0xFFFF -> `eos_o`=1 and all later packets dropped.
